// File: rtl/bcd_to_binary_pkg.sv
// +----------------------------------------------------------------------+
// | bcd_pkg : shared constants, state type and sizing helper for BCD->bin |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package bcd_pkg;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_SUB    = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest width w with 2^w >= 10^digits, i.e. able to hold 10^digits - 1.
  function automatic int unsigned bcd_min_bin_w(input int unsigned digits);
    longint unsigned lim;
    int unsigned     w;
    lim = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      lim = lim * 64'd10;
    end
    w = 0;
    while ((64'd1 << w) < lim) begin
      w++;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// +----------------------------------------------------------------------+
// | bcd_digit_adjust : per-digit correction step of reverse double-dabble |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i - ADJ_SUB) : digit_i;

endmodule

`default_nettype wire

// File: rtl/bcd_to_binary.sv
// +----------------------------------------------------------------------+
// | bcd_to_binary : sequential packed-BCD to binary converter, one bit per |
// | cycle. Optional macro BCD_DIGIT_CHECK_EN flags digits > 9 as errors.   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = bcd_min_bin_w(DIGITS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DIGIT_W*DIGITS-1:0]   bcd_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [BIN_W-1:0]            bin_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        err
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   work_bcd_q, work_bcd_d;
  logic [BIN_W-1:0]   work_bin_q, work_bin_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               out_valid_q, out_valid_d;

  logic [BCD_W-1:0]   shift_bcd;
  logic [BCD_W-1:0]   adj_bcd;
  logic [BIN_W-1:0]   shift_bin;

  // The BCD LSB falls into the binary MSB on every iteration.
  assign shift_bcd = {1'b0, work_bcd_q[BCD_W-1:1]};
  assign shift_bin = {work_bcd_q[0], work_bin_q[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit_adj
    bcd_digit_adjust u_adj (
      .digit_i (shift_bcd[g*DIGIT_W +: DIGIT_W]),
      .digit_o (adj_bcd[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic err_q, err_d;
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[i*DIGIT_W +: DIGIT_W] > BCD_MAX) begin
        bad_digit = 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign bin_out   = bin_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_bcd_d  = work_bcd_q;
    work_bin_d  = work_bin_q;
    bin_d       = bin_q;
    out_valid_d = out_valid_q;
`ifdef BCD_DIGIT_CHECK_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_bcd_d = bcd_in;
          work_bin_d = '0;
          cnt_d      = CNT_W'(BIN_W);
          state_d    = SHIFT;
`ifdef BCD_DIGIT_CHECK_EN
          if (bad_digit) begin
            bin_d       = '0;
            out_valid_d = 1'b1;
            err_d       = 1'b1;
            state_d     = DONE;
          end
`endif
        end
      end
      SHIFT: begin
        work_bcd_d = adj_bcd;
        work_bin_d = shift_bin;
        cnt_d      = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          bin_d       = shift_bin;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef BCD_DIGIT_CHECK_EN
          err_d       = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_bcd_q  <= '0;
      work_bin_q  <= '0;
      bin_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_bcd_q  <= work_bcd_d;
      work_bin_q  <= work_bin_d;
      bin_q       <= bin_d;
      out_valid_q <= out_valid_d;
`ifdef BCD_DIGIT_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary.sv
// +----------------------------------------------------------------------+
// | tb_bcd_to_binary : self-checking bench for bcd_to_binary              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bcd_to_binary;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk;
  logic              reset;
  logic [11:0]       bcd_in;
  logic              in_valid;
  logic              in_ready;
  logic [BIN_W-1:0]  bin_out;
  logic              out_valid;
  logic              out_ready;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_out   (bin_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  // Decimal value of a packed BCD word, digit by digit.
  function automatic int ref_bcd(input logic [11:0] b);
    int v;
    v = 0;
    for (int k = DIGITS - 1; k >= 0; k--) v = v * 10 + int'(b[4*k +: 4]);
    return v;
  endfunction

  task automatic start_req(input logic [11:0] b);
    @(negedge clk);
    bcd_in   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bcd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, err, bin_out} !== {1'b1, 1'b0, 1'b0, 10'd0}) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b err=%b bin=%0d, want rdy=1 vld=0 err=0 bin=0",
               in_ready, out_valid, err, bin_out);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset_idle: rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_single(input logic [11:0] b);
    int lat;
    int exp;
    exp = ref_bcd(b);
    out_ready = 1'b1;
    start_req(b);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ready %h: rdy=%b, want 0", b, in_ready);
    end
    wait_valid(lat);
    n_checks++;
    if (lat !== 10) begin
      n_fail++;
      $display("FAIL latency %h: got %0d cycles, want 10", b, lat);
    end
    n_checks++;
    if ({err, bin_out} !== {1'b0, BIN_W'(exp)}) begin
      n_fail++;
      $display("FAIL result %h: bin=%0d err=%b, want bin=%0d err=0", b, bin_out, err, exp);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_handshake %h: rdy=%b vld=%b, want rdy=1 vld=0", b, in_ready, out_valid);
    end
  endtask

  task automatic test_extremes;
    test_single(12'h000);
    test_single(12'h999);
    test_single(12'h100);
  endtask

  task automatic test_backpressure;
    int lat;
    int hs0;
    out_ready = 1'b0;
    start_req(12'h042);
    wait_valid(lat);
    n_checks++;
    if (lat !== 10) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d, want 10", lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      bcd_in   = 12'h123;
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, bin_out} !== {1'b1, 1'b0, 10'd42}) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: vld=%b rdy=%b bin=%0d, want vld=1 rdy=0 bin=42",
                 c, out_valid, in_ready, bin_out);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    hs0 = hs_cnt;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({hs_cnt - hs0, out_valid, in_ready} !== {32'd1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_release: handshakes=%0d vld=%b rdy=%b, want 1 handshake vld=0 rdy=1",
               hs_cnt - hs0, out_valid, in_ready);
    end
  endtask

  task automatic test_sweep;
    int hs0;
    hs0 = hs_cnt;
    for (int i = 0; i < 1000; i++) begin
      logic [11:0]      b;
      logic [BIN_W-1:0] res;
      bit               got;
      int               guard;
      b = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
      @(negedge clk);
      bcd_in    = b;
      in_valid  = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      got = 1'b0; guard = 0; res = '0;
      while (!got && guard < 100) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          res = bin_out;
          got = 1'b1;
        end
        @(posedge clk);
        guard++;
      end
      n_checks++;
      if (!got || res !== BIN_W'(i)) begin
        n_fail++;
        $display("FAIL sweep %h: got=%0d seen=%b, want %0d", b, res, got, i);
      end
    end
    #1;
    n_checks++;
    if (hs_cnt - hs0 !== 1000) begin
      n_fail++;
      $display("FAIL sweep_count: %0d handshakes, want 1000", hs_cnt - hs0);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    @(negedge clk);
    start_req(12'h500);
    repeat (4) @(posedge clk);
    #2;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_busy: rdy=%b, want 0", in_ready);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, err, bin_out} !== {1'b1, 1'b0, 1'b0, 10'd0}) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b vld=%b err=%b bin=%0d, want rdy=1 vld=0 err=0 bin=0",
               in_ready, out_valid, err, bin_out);
    end
    @(negedge clk) reset = 1'b0;
    test_single(12'h007);
  endtask

  task automatic test_invalid_digit;
    int lat;
    out_ready = 1'b1;
    start_req(12'h2A5);
    wait_valid(lat);
`ifdef BCD_DIGIT_CHECK_EN
    n_checks++;
    if ({lat == 1, err, bin_out} !== {1'b1, 1'b1, 10'd0}) begin
      n_fail++;
      $display("FAIL bad_digit: lat=%0d err=%b bin=%0d, want lat=1 err=1 bin=0", lat, err, bin_out);
    end
`else
    n_checks++;
    if ({lat == 10, err} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL bad_digit_nocheck: lat=%0d err=%b, want lat=10 err=0", lat, err);
    end
`endif
    @(posedge clk); #1;
    n_checks++;
    if ({err, out_valid, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL bad_digit_clear: err=%b vld=%b rdy=%b, want err=0 vld=0 rdy=1",
               err, out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset;
    test_single(12'h255);
    test_extremes;
    test_backpressure;
    test_sweep;
    test_reset_mid;
    test_invalid_digit;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
